icache_axi_rd_bridge: RTL and testbench
=======================================

# icache_axi_rd_bridge

Converts the instruction cache's simple refill-read port (rd_req/rd_type/rd_addr → rd_rdy/ret_valid/ret_last/ret_data) into AXI4 AR/R channel transactions. It sits directly downstream of the instruction cache and upstream of the core's AXI arbiter/interconnect. It issues one outstanding read at a time, registers every returned beat before handing it to the cache, and enforces beat-count/rlast consistency.

## Interface
Parameters:
- ARID, 4'd0, constant AXI ID driven on arid
- LINE_BEATS, 4, beats per cache-line refill (arlen = LINE_BEATS-1)

Ports:
- clk  in  1  core clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- rd_req  in  1  cache read request, held until rd_rdy
- rd_type  in  3  3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 cache line
- rd_addr  in  32  request address
- rd_rdy  out  1  bridge can accept a request this cycle
- ret_valid  out  1  returned beat valid (one cycle per beat)
- ret_last  out  1  final beat of the transaction
- ret_data  out  32  returned beat data
- arid  out  4  = ARID
- araddr  out  32  read address
- arlen  out  8  burst length minus one
- arsize  out  3  beat size
- arburst  out  2  2'b01 INCR
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  ignored except for check (must equal ARID)
- rdata  in  32  R data
- rresp  in  2  R response
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready
- rd_err  out  1  sticky protocol/response error flag

## Operation
- States: IDLE, AR, R.
- IDLE: rd_rdy=1. On rd_req: latch address/len/size, go AR.
- Latching: line → araddr={rd_addr[31:4],4'b0}, arlen=LINE_BEATS-1, arsize=3'b010; byte/half/word → araddr=rd_addr, arlen=0, arsize=rd_type[1:0]. Any other rd_type: treated as word, rd_err set.
- AR: arvalid=1, address fields stable; on arready → R, beat counter cleared.
- R: rready=1. Each rvalid beat: beat counter increments (2-bit wrap irrelevant; counter width 3 bits); data/last registered to ret_*.
- ret_last is asserted when counter == arlen, regardless of rlast; rlast≠(counter==arlen), rid≠ARID, or rresp≠2'b00 sets rd_err. Data still forwarded.
- Transaction ends on the beat where counter==arlen (not on rlast) → IDLE.
- rd_err clears only on reset.

## Timing
- Reset values: rd_rdy=0 during reset then 1 in IDLE; arvalid=0, rready=0, ret_valid=0, ret_last=0, ret_data=0, araddr=0, arlen=0, arsize=0, rd_err=0; arburst=2'b01, arid=ARID constant.
- Request accepted at cycle T (rd_req&&rd_rdy) → arvalid=1 from T+1; rd_rdy=0 from T+1.
- AR handshake at cycle A → rready=1 from A+1.
- Beat accepted at cycle B → ret_valid/ret_data/ret_last at B+1 for exactly one cycle.
- Last beat at cycle L → state IDLE at L+1, rd_rdy=1 at L+1 (new request can be accepted same cycle as final ret_valid).
- Minimum word read latency: request→ret_valid = 3 cycles with arready and rvalid immediately high.
- No backpressure from cache: rready never deasserts in R.
- rvalid in IDLE/AR is ignored (rready=0) and does not set rd_err.
- Asynchronous reset mid-transaction: state→IDLE immediately, all outputs to reset values; in-flight AXI transaction abandoned (interconnect is reset concurrently).

## Structure
- Shared package la_axi_pkg: rd_type encodings (RD_BYTE, RD_HALF, RD_WORD, RD_LINE), AXI burst constant AXI_BURST_INCR, AXI size constants, RESP_OKAY, state enum.
- Single module, no sub-module; state register, latched request, 3-bit beat counter, registered return stage.

## Test plan
- Line refill, rd_addr=0x1C00_0048, arready/rvalid always high, data 0xA0..0xA3 → araddr=0x1C00_0040, arlen=3, arsize=2; ret_valid 4 consecutive cycles, ret_last on 0xA3; rd_rdy=1 next cycle.
- Uncached word, rd_addr=0x1FD0_0004, arready delayed 5 cycles → arvalid held 6 cycles with stable fields; single ret_valid+ret_last, rd_err=0.
- Line refill with rvalid gaps (1-0-0-1-1-0-1) → exactly 4 ret_valid pulses each one cycle after its beat; order preserved.
- Slave asserts rlast on beat 2 of 4 / rresp=2'b10 → rd_err=1 sticky; ret_last still on 4th beat; bridge returns to IDLE.
- Back-to-back: second rd_req high during final ret_valid → accepted that cycle, arvalid next cycle.
- resetn pulsed low during R after 2 beats → all outputs reset immediately; after release, rd_rdy=1 and fresh line read completes normally.

Source files
------------

// File: rtl/la_axi_pkg.sv
// Shared encodings for the cache-side refill port and AXI4 read channel fields.
package la_axi_pkg;

  localparam logic [2:0] RD_BYTE = 3'b000;
  localparam logic [2:0] RD_HALF = 3'b001;
  localparam logic [2:0] RD_WORD = 3'b010;
  localparam logic [2:0] RD_LINE = 3'b100;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_1B    = 3'b000;
  localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } br_state_e;

endpackage

// File: rtl/icache_axi_rd_bridge.sv
// Instruction-cache refill port to AXI4 AR/R bridge: one outstanding read,
// registered return beats, sticky error on response/ID/rlast inconsistencies.
module icache_axi_rd_bridge
  import la_axi_pkg::*;
#(
  parameter logic [3:0] ARID       = 4'd0,
  parameter int         LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rd_req,
  input  logic [2:0]  rd_type,
  input  logic [31:0] rd_addr,
  output logic        rd_rdy,
  output logic        ret_valid,
  output logic        ret_last,
  output logic [31:0] ret_data,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rd_err
);

  localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);

  br_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rdy_q, rdy_d;
  logic        rv_q, rv_d;
  logic        rl_q, rl_d;
  logic [31:0] rdat_q, rdat_d;
  logic        err_q, err_d;
  logic        last_beat;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    rv_d      = 1'b0;
    rl_d      = 1'b0;
    rdat_d    = rdat_q;
    err_d     = err_q;
    last_beat = ({5'b0, cnt_q} == len_q);

    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          state_d = ST_AR;
          case (rd_type)
            RD_LINE: begin
              addr_d = {rd_addr[31:4], 4'b0};
              len_d  = LINE_LEN;
              size_d = AXI_SIZE_4B;
            end
            RD_BYTE, RD_HALF, RD_WORD: begin
              addr_d = rd_addr;
              len_d  = 8'd0;
              size_d = {1'b0, rd_type[1:0]};
            end
            default: begin
              // Unknown encodings still complete as a word read so the cache is not hung.
              addr_d = rd_addr;
              len_d  = 8'd0;
              size_d = AXI_SIZE_4B;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      ST_AR: begin
        if (arready) begin
          state_d = ST_R;
          cnt_d   = 3'd0;
        end
      end
      ST_R: begin
        if (rvalid) begin
          rv_d   = 1'b1;
          rdat_d = rdata;
          rl_d   = last_beat;
          cnt_d  = cnt_q + 3'd1;
          if ((rlast != last_beat) || (rid != ARID) || (rresp != RESP_OKAY)) begin
            err_d = 1'b1;
          end
          // Our own beat count, not rlast, decides when the burst is over.
          if (last_beat) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      rv_q    <= 1'b0;
      rl_q    <= 1'b0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      rv_q    <= rv_d;
      rl_q    <= rl_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  assign rd_rdy    = rdy_q;
  assign ret_valid = rv_q;
  assign ret_last  = rl_q;
  assign ret_data  = rdat_q;
  assign arid      = ARID;
  assign araddr    = addr_q;
  assign arlen     = len_q;
  assign arsize    = size_q;
  assign arburst   = AXI_BURST_INCR;
  assign arvalid   = (state_q == ST_AR);
  assign rready    = (state_q == ST_R);
  assign rd_err    = err_q;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Scoreboard bench for icache_axi_rd_bridge: a scripted AXI slave pushes each
// accepted beat's expected return, and a monitor pops and compares it.
module tb_icache_axi_rd_bridge;

  localparam logic [3:0] ARID_T = 4'd0;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy, ret_valid, ret_last;
  logic [31:0] ret_data;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, rd_err;

  icache_axi_rd_bridge #(.ARID(ARID_T), .LINE_BEATS(4)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        l;
    int unsigned c;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned last_ret_cyc = 0;
  int unsigned req_cyc = 0;
  int          mdl_cnt = 0;
  logic [7:0]  cur_len = 8'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Return beat must appear exactly one cycle after its R handshake.
  always @(negedge clk) begin
    if (resetn) begin
      if (sb.size() > 0 && sb[0].c < cyc) begin
        chk("ret_missing", 64'd0, 64'd1);
        void'(sb.pop_front());
      end
      if (ret_valid) begin
        last_ret_cyc = cyc;
        if (sb.size() == 0) begin
          chk("ret_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ret_cycle", 64'(cyc), 64'(mon_e.c));
          chk("ret_data", 64'(ret_data), 64'(mon_e.d));
          chk("ret_last", 64'(ret_last), 64'(mon_e.l));
        end
      end
    end
  end

  task automatic do_req(input logic [2:0] t, input logic [31:0] a, input logic [7:0] len);
    rd_req  = 1'b1;
    rd_type = t;
    rd_addr = a;
    cur_len = len;
    mdl_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (rd_rdy) begin
        req_cyc = cyc;
        @(negedge clk);
        rd_req = 1'b0;
        chk("arvalid_after_req", 64'(arvalid), 64'd1);
        chk("rdrdy_after_req", 64'(rd_rdy), 64'd0);
        return;
      end
      @(negedge clk);
    end
    chk("req_timeout", 64'd0, 64'd1);
    rd_req = 1'b0;
  endtask

  task automatic do_ar(input int dly, input logic [31:0] ea, input logic [7:0] el,
                       input logic [2:0] es);
    arready = 1'b0;
    for (int i = 0; i < dly; i++) begin
      chk("arvalid_hold", 64'(arvalid), 64'd1);
      chk("araddr_hold", 64'(araddr), 64'(ea));
      chk("arlen_hold", 64'(arlen), 64'(el));
      @(negedge clk);
    end
    arready = 1'b1;
    chk("arvalid", 64'(arvalid), 64'd1);
    chk("araddr", 64'(araddr), 64'(ea));
    chk("arlen", 64'(arlen), 64'(el));
    chk("arsize", 64'(arsize), 64'(es));
    chk("arburst", 64'(arburst), 64'd1);
    chk("arid", 64'(arid), 64'(ARID_T));
    @(negedge clk);
    arready = 1'b0;
    chk("arvalid_drop", 64'(arvalid), 64'd0);
  endtask

  task automatic do_beat(input logic [31:0] dat, input logic l, input logic [1:0] r);
    rvalid = 1'b1;
    rdata  = dat;
    rlast  = l;
    rresp  = r;
    rid    = ARID_T;
    for (int i = 0; i < 100; i++) begin
      if (rready) begin
        sb.push_back('{d: dat, l: (mdl_cnt == int'(cur_len)), c: cyc + 1});
        mdl_cnt++;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    rvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_rdy"}, 64'(rd_rdy), 64'd0);
    chk({tag, "_arvalid"}, 64'(arvalid), 64'd0);
    chk({tag, "_rready"}, 64'(rready), 64'd0);
    chk({tag, "_ret_valid"}, 64'(ret_valid), 64'd0);
    chk({tag, "_ret_last"}, 64'(ret_last), 64'd0);
    chk({tag, "_ret_data"}, 64'(ret_data), 64'd0);
    chk({tag, "_araddr"}, 64'(araddr), 64'd0);
    chk({tag, "_arlen"}, 64'(arlen), 64'd0);
    chk({tag, "_arsize"}, 64'(arsize), 64'd0);
    chk({tag, "_rd_err"}, 64'(rd_err), 64'd0);
    chk({tag, "_arburst"}, 64'(arburst), 64'd1);
    chk({tag, "_arid"}, 64'(arid), 64'(ARID_T));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; rd_req = 1'b0; rd_type = 3'b000; rd_addr = '0;
    arready = 1'b0; rid = ARID_T; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    resetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_rdy", 64'(rd_rdy), 64'd1);

    // Stray R traffic while idle must be ignored.
    rvalid = 1'b1; rlast = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      chk("idle_rready", 64'(rready), 64'd0);
      chk("idle_ret_valid", 64'(ret_valid), 64'd0);
    end
    idle(1);
    chk("idle_err", 64'(rd_err), 64'd0);

    // Line refill, no stalls.
    do_req(3'b100, 32'h1C00_0048, 8'd3);
    do_ar(0, 32'h1C00_0040, 8'd3, 3'b010);
    for (int i = 0; i < 4; i++) do_beat(32'hA0 + 32'(i), (i == 3), 2'b00);
    rvalid = 1'b0;
    chk("t1_rdy_after_last", 64'(rd_rdy), 64'd1);
    idle(2);
    chk("t1_err", 64'(rd_err), 64'd0);

    // Uncached word with arready held off 5 cycles.
    do_req(3'b010, 32'h1FD0_0004, 8'd0);
    do_ar(5, 32'h1FD0_0004, 8'd0, 3'b010);
    do_beat(32'h1234_5678, 1'b1, 2'b00);
    idle(2);
    chk("t2_err", 64'(rd_err), 64'd0);
    chk("t2_rdy", 64'(rd_rdy), 64'd1);

    // Line refill with rvalid pattern 1-0-0-1-1-0-1.
    do_req(3'b100, 32'h0000_1234, 8'd3);
    do_ar(0, 32'h0000_1230, 8'd3, 3'b010);
    do_beat(32'hB0, 1'b0, 2'b00);
    idle(2);
    do_beat(32'hB1, 1'b0, 2'b00);
    do_beat(32'hB2, 1'b0, 2'b00);
    idle(1);
    do_beat(32'hB3, 1'b1, 2'b00);
    idle(2);
    chk("t3_err", 64'(rd_err), 64'd0);

    // Early rlast and SLVERR: data still flows, ret_last follows our count.
    do_req(3'b100, 32'h2000_0010, 8'd3);
    do_ar(0, 32'h2000_0010, 8'd3, 3'b010);
    do_beat(32'hC0, 1'b0, 2'b00);
    do_beat(32'hC1, 1'b1, 2'b00);
    do_beat(32'hC2, 1'b0, 2'b10);
    do_beat(32'hC3, 1'b0, 2'b00);
    rvalid = 1'b0;
    chk("t4_err", 64'(rd_err), 64'd1);
    chk("t4_rdy", 64'(rd_rdy), 64'd1);
    idle(2);
    chk("t4_err_sticky", 64'(rd_err), 64'd1);

    // Back-to-back: next request during the final return beat.
    do_req(3'b100, 32'h3000_0000, 8'd3);
    do_ar(0, 32'h3000_0000, 8'd3, 3'b010);
    for (int i = 0; i < 4; i++) do_beat(32'hD0 + 32'(i), (i == 3), 2'b00);
    rvalid = 1'b0;
    chk("t5_ret_valid_overlap", 64'(ret_valid), 64'd1);
    chk("t5_rdy_overlap", 64'(rd_rdy), 64'd1);
    do_req(3'b010, 32'h3000_0104, 8'd0);
    do_ar(0, 32'h3000_0104, 8'd0, 3'b010);
    do_beat(32'hE0, 1'b1, 2'b00);
    idle(1);
    chk("t5_word_latency", 64'(last_ret_cyc - req_cyc), 64'd3);
    chk("t5_err_sticky", 64'(rd_err), 64'd1);
    idle(1);

    // Reset in the middle of a line refill after two beats.
    do_req(3'b100, 32'h4000_0020, 8'd3);
    do_ar(0, 32'h4000_0020, 8'd3, 3'b010);
    do_beat(32'hF0, 1'b0, 2'b00);
    do_beat(32'hF1, 1'b0, 2'b00);
    idle(2);
    chk("t6_rready_pre", 64'(rready), 64'd1);
    resetn = 1'b0;
    #1;
    chk_reset_vals("t6");
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("t6_rdy_after", 64'(rd_rdy), 64'd1);
    do_req(3'b100, 32'h4000_0020, 8'd3);
    do_ar(0, 32'h4000_0020, 8'd3, 3'b010);
    for (int i = 0; i < 4; i++) do_beat(32'h50 + 32'(i), (i == 3), 2'b00);
    idle(2);
    chk("t6_err", 64'(rd_err), 64'd0);

    // Byte read, then an undefined rd_type completing as a word with error.
    do_req(3'b000, 32'h6000_0003, 8'd0);
    do_ar(0, 32'h6000_0003, 8'd0, 3'b000);
    do_beat(32'h0000_0077, 1'b1, 2'b00);
    idle(2);
    chk("t7_byte_err", 64'(rd_err), 64'd0);
    do_req(3'b011, 32'h5000_0002, 8'd0);
    do_ar(0, 32'h5000_0002, 8'd0, 3'b010);
    do_beat(32'h0000_0099, 1'b1, 2'b00);
    idle(2);
    chk("t7_bad_type_err", 64'(rd_err), 64'd1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
